// File: rtl/bcd_entry.sv
// Three-digit BCD keypad entry: debounced pushbuttons build a signed decimal number,
// which is converted to 12-bit two's complement and held until the processor acknowledges it.
module bcd_entry #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [3:0]  digit_in,
   input  logic        key_digit,
   input  logic        key_sign,
   input  logic        key_enter,
   input  logic        key_clear,
   input  logic        ack,
   output logic [11:0] value,
   output logic        valid,
   output logic [11:0] bcd,
   output logic        neg,
   output logic        err,
   output logic        busy
);

   localparam int unsigned CntW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

   localparam int unsigned KDig   = 0;
   localparam int unsigned KSign  = 1;
   localparam int unsigned KEnter = 2;
   localparam int unsigned KClear = 3;

   typedef enum logic [1:0] {StEntry, StConvert, StHold} state_e;

   // ---------------------------------------------------------------------------------------
   // Key conditioning: synchronizer, debouncer, falling-edge press pulse
   // ---------------------------------------------------------------------------------------
   logic [3:0]      key_raw;
   logic [3:0]      sync1_q, sync2_q;
   logic [3:0]      deb_q, deb_d;
   logic [3:0]      deb_prev_q;
   logic [3:0]      press_q, press_d;
   logic [3:0]      armed_q, armed_d;
   logic [1:0]      settle_q, settle_d;
   logic [CntW-1:0] cnt_q [4];
   logic [CntW-1:0] cnt_d [4];

   assign key_raw = {key_clear, key_enter, key_sign, key_digit};

   always_comb begin
      deb_d    = deb_q;
      armed_d  = armed_q;
      settle_d = settle_q;
      for (int i = 0; i < 4; i++) begin
         cnt_d[i] = '0;
      end
      if (settle_q != 2'd2) begin
         settle_d = settle_q + 2'd1;
      end
      for (int i = 0; i < 4; i++) begin
         if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == CntMax) begin
               deb_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
         // A key only becomes usable once it has been seen released after reset.
         if (settle_q == 2'd2 && sync2_q[i]) begin
            armed_d[i] = 1'b1;
         end
      end
      press_d = deb_prev_q & ~deb_q & armed_q;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q    <= '1;
         sync2_q    <= '1;
         deb_q      <= '1;
         deb_prev_q <= '1;
         press_q    <= '0;
         armed_q    <= '0;
         settle_q   <= '0;
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q    <= key_raw;
         sync2_q    <= sync1_q;
         deb_q      <= deb_d;
         deb_prev_q <= deb_q;
         press_q    <= press_d;
         armed_q    <= armed_d;
         settle_q   <= settle_d;
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // ---------------------------------------------------------------------------------------
   // Entry / conversion FSM
   // ---------------------------------------------------------------------------------------
   state_e      state_q, state_d;
   logic [11:0] bcd_q, bcd_d;
   logic [1:0]  dcnt_q, dcnt_d;
   logic        neg_q, neg_d;
   logic        err_q, err_d;
   logic [9:0]  acc_q, acc_d;
   logic [1:0]  step_q, step_d;
   logic [11:0] value_q, value_d;
   logic        valid_q, valid_d;
   logic        busy_q, busy_d;
   logic [3:0]  cur_digit;
   logic [9:0]  acc_next;

   always_comb begin
      state_d = state_q;
      bcd_d   = bcd_q;
      dcnt_d  = dcnt_q;
      neg_d   = neg_q;
      err_d   = err_q;
      acc_d   = acc_q;
      step_d  = step_q;
      value_d = value_q;

      unique case (step_q)
         2'd0:    cur_digit = bcd_q[11:8];
         2'd1:    cur_digit = bcd_q[7:4];
         default: cur_digit = bcd_q[3:0];
      endcase
      acc_next = acc_q * 10'd10 + {6'd0, cur_digit};

      unique case (state_q)
         StEntry: begin
            if (press_q[KClear]) begin
               bcd_d  = '0;
               dcnt_d = '0;
               neg_d  = 1'b0;
               err_d  = 1'b0;
            end else if (press_q[KEnter]) begin
               err_d   = 1'b0;
               acc_d   = '0;
               step_d  = '0;
               state_d = StConvert;
            end else if (press_q[KSign]) begin
               neg_d = ~neg_q;
            end else if (press_q[KDig]) begin
               if (digit_in > 4'd9) begin
                  err_d = 1'b1;
               end else begin
                  err_d = 1'b0;
                  if (dcnt_q != 2'd3) begin
                     bcd_d  = {bcd_q[7:0], digit_in};
                     dcnt_d = dcnt_q + 2'd1;
                  end
               end
            end
         end
         StConvert: begin
            acc_d  = acc_next;
            step_d = step_q + 2'd1;
            if (step_q == 2'd2) begin
               value_d = neg_q ? (12'd0 - {2'b00, acc_next}) : {2'b00, acc_next};
               state_d = StHold;
            end
         end
         StHold: begin
            // Ack outranks clear; both leave the entered digits and sign cleared.
            if (ack || press_q[KClear]) begin
               state_d = StEntry;
               bcd_d   = '0;
               dcnt_d  = '0;
               neg_d   = 1'b0;
               err_d   = 1'b0;
            end
         end
         default: state_d = StEntry;
      endcase

      valid_d = (state_d == StHold);
      busy_d  = (state_d != StEntry);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StEntry;
         bcd_q   <= '0;
         dcnt_q  <= '0;
         neg_q   <= 1'b0;
         err_q   <= 1'b0;
         acc_q   <= '0;
         step_q  <= '0;
         value_q <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         bcd_q   <= bcd_d;
         dcnt_q  <= dcnt_d;
         neg_q   <= neg_d;
         err_q   <= err_d;
         acc_q   <= acc_d;
         step_q  <= step_d;
         value_q <= value_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   assign value = value_q;
   assign valid = valid_q;
   assign bcd   = bcd_q;
   assign neg   = neg_q;
   assign err   = err_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_bcd_entry.sv
// Bench for bcd_entry: directed scenarios plus random keypad sessions, checked against
// a decimal-digit model of the entered number.
module tb_bcd_entry;

   localparam int D = 4;
   localparam int E = 2 + D;   // press pulse cycle relative to the first low-sampling edge

   logic        clock = 1'b0;
   logic        reset_n = 1'b1;
   logic [3:0]  digit_in = 4'd0;
   logic        key_digit = 1'b1, key_sign = 1'b1, key_enter = 1'b1, key_clear = 1'b1;
   logic        ack = 1'b0;
   logic [11:0] value, bcd;
   logic        valid, neg, err, busy;

   int errors = 0;
   int checks = 0;

   int          m_digits[$];
   bit          m_neg;
   bit          m_err;
   logic [11:0] m_value;

   bcd_entry #(.DEBOUNCE_CYCLES(D)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .digit_in  (digit_in),
      .key_digit (key_digit),
      .key_sign  (key_sign),
      .key_enter (key_enter),
      .key_clear (key_clear),
      .ack       (ack),
      .value     (value),
      .valid     (valid),
      .bcd       (bcd),
      .neg       (neg),
      .err       (err),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] model_bcd();
      int r = 0;
      foreach (m_digits[i]) r = r * 16 + m_digits[i];
      return 12'(r);
   endfunction

   function automatic int model_num();
      int r = 0;
      foreach (m_digits[i]) r = r * 10 + m_digits[i];
      return r;
   endfunction

   task automatic model_clear();
      m_digits.delete();
      m_neg = 1'b0;
      m_err = 1'b0;
   endtask

   task automatic set_keys(input logic [3:0] m);  // bit0 digit, 1 sign, 2 enter, 3 clear
      key_digit = ~m[0];
      key_sign  = ~m[1];
      key_enter = ~m[2];
      key_clear = ~m[3];
   endtask

   task automatic press(input logic [3:0] m);
      @(negedge clock);
      set_keys(m);
      repeat (12) @(posedge clock);
      @(negedge clock);
      set_keys(4'b0000);
      repeat (10) @(posedge clock);
      #1;
   endtask

   task automatic check_entry(input string tag);
      chk({tag, "_bcd"}, {4'd0, bcd}, {4'd0, model_bcd()});
      chk({tag, "_neg"}, {15'd0, neg}, {15'd0, m_neg});
      chk({tag, "_err"}, {15'd0, err}, {15'd0, m_err});
      chk({tag, "_valid"}, {15'd0, valid}, 16'd0);
      chk({tag, "_busy"}, {15'd0, busy}, 16'd0);
   endtask

   task automatic do_digit(input int d);
      digit_in = 4'(d);
      press(4'b0001);
      if (d > 9) m_err = 1'b1;
      else begin
         m_err = 1'b0;
         if (m_digits.size() < 3) m_digits.push_back(d);
      end
      check_entry("digit");
   endtask

   task automatic do_sign();
      press(4'b0010);
      m_neg = ~m_neg;
      check_entry("sign");
   endtask

   task automatic do_clear();
      press(4'b1000);
      model_clear();
      check_entry("clear");
   endtask

   task automatic do_enter();
      int n;
      n = model_num();
      m_err = 1'b0;
      m_value = m_neg ? 12'((4096 - n) % 4096) : 12'(n);
      @(negedge clock);
      set_keys(4'b0100);
      for (int c = 0; c <= E + 4; c++) begin
         @(posedge clock);
         #1;
         if (c == E) chk("busy_before", {15'd0, busy}, 16'd0);
         if (c == E + 1) begin
            chk("busy_e1", {15'd0, busy}, 16'd1);
            chk("valid_e1", {15'd0, valid}, 16'd0);
         end
         if (c == E + 3) chk("valid_e3", {15'd0, valid}, 16'd0);
         if (c == E + 4) begin
            chk("valid_e4", {15'd0, valid}, 16'd1);
            chk("busy_e4", {15'd0, busy}, 16'd1);
            chk("value_e4", {4'd0, value}, {4'd0, m_value});
         end
      end
      @(negedge clock);
      set_keys(4'b0000);
      repeat (10) @(posedge clock);
      #1;
      chk("hold_valid", {15'd0, valid}, 16'd1);
      chk("hold_value", {4'd0, value}, {4'd0, m_value});
      chk("hold_bcd", {4'd0, bcd}, {4'd0, model_bcd()});
      chk("hold_neg", {15'd0, neg}, {15'd0, m_neg});
      chk("hold_err", {15'd0, err}, 16'd0);
   endtask

   task automatic do_ack();
      @(negedge clock);
      ack = 1'b1;
      @(posedge clock);
      #1;
      ack = 1'b0;
      model_clear();
      chk("ack_value_kept", {4'd0, value}, {4'd0, m_value});
      check_entry("ack");
   endtask

   task automatic hold_ignore();
      digit_in = 4'd5;
      press(4'b0001);
      press(4'b0010);
      press(4'b0100);
      chk("ign_valid", {15'd0, valid}, 16'd1);
      chk("ign_bcd", {4'd0, bcd}, {4'd0, model_bcd()});
      chk("ign_neg", {15'd0, neg}, {15'd0, m_neg});
      chk("ign_value", {4'd0, value}, {4'd0, m_value});
   endtask

   initial begin
      int n;
      bit vseen;
      model_clear();
      m_value = 12'd0;

      // Reset state
      #3 reset_n = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_value", {4'd0, value}, 16'd0);
      check_entry("rst");
      @(negedge clock);
      reset_n = 1'b1;
      repeat (5) @(posedge clock);
      #1;

      // 123 -> 0x07B, ignored presses in HOLD, then ack
      do_digit(1); do_digit(2); do_digit(3);
      do_enter();
      hold_ignore();
      do_ack();

      // -999 -> 0xC19
      do_digit(9); do_digit(9); do_digit(9);
      do_sign();
      do_enter();
      do_ack();

      // Fourth digit ignored, bad digit flags err, later valid digit clears it
      do_digit(4); do_digit(5); do_digit(6); do_digit(7);
      do_digit(12);
      do_digit(0);
      do_clear();

      // Bouncing press yields one toggle; a short glitch yields none
      @(negedge clock) key_sign = 1'b0;
      repeat (2) @(negedge clock);
      key_sign = 1'b1;
      @(negedge clock) key_sign = 1'b0;
      repeat (12) @(negedge clock);
      key_sign = 1'b1;
      repeat (12) @(negedge clock);
      m_neg = ~m_neg;
      check_entry("bounce");
      key_sign = 1'b0;
      repeat (3) @(negedge clock);
      key_sign = 1'b1;
      repeat (12) @(negedge clock);
      check_entry("glitch");
      do_clear();

      // Clear and enter together: clear wins
      do_digit(0); do_digit(4); do_digit(2);
      chk("pre_both_bcd", {4'd0, bcd}, 16'h0042);
      press(4'b1100);
      model_clear();
      check_entry("clr_ent");

      // Abort in HOLD by clear
      do_digit(8);
      do_enter();
      press(4'b1000);
      model_clear();
      check_entry("hold_clr");

      // Reset during CONVERT
      do_digit(5);
      @(negedge clock);
      set_keys(4'b0100);
      n = 0;
      while (busy !== 1'b1 && n < 40) begin
         @(posedge clock);
         #1;
         n++;
      end
      chk("busy_seen", {15'd0, busy}, 16'd1);
      #2 reset_n = 1'b0;
      #1;
      model_clear();
      m_value = 12'd0;
      chk("rstc_value", {4'd0, value}, 16'd0);
      check_entry("rstc");
      set_keys(4'b0000);
      repeat (3) @(posedge clock);
      @(negedge clock) reset_n = 1'b1;
      vseen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clock);
         #1;
         if (valid === 1'b1) vseen = 1'b1;
      end
      chk("no_valid_after_rst", {15'd0, vseen}, 16'd0);
      do_sign();
      do_enter();
      do_ack();

      // Key held through reset produces no press until re-pressed
      @(negedge clock) key_sign = 1'b0;
      repeat (12) @(posedge clock);
      @(negedge clock) reset_n = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock) reset_n = 1'b1;
      repeat (20) @(posedge clock);
      #1;
      model_clear();
      check_entry("held");
      @(negedge clock) key_sign = 1'b1;
      repeat (10) @(posedge clock);
      #1;
      check_entry("held_rel");
      do_sign();
      do_clear();

      // Random sessions
      for (int r = 0; r < 8; r++) begin
         n = int'($urandom_range(1, 6));
         for (int k = 0; k < n; k++) begin
            case ($urandom_range(0, 9))
               0, 1, 2, 3, 4, 5: do_digit(int'($urandom_range(0, 11)));
               6, 7:             do_sign();
               default:          if ($urandom_range(0, 2) == 0) do_clear();
                                 else do_digit(int'($urandom_range(0, 9)));
            endcase
         end
         do_enter();
         if ($urandom_range(0, 2) == 0) begin
            press(4'b1000);
            model_clear();
            check_entry("rnd_hold_clr");
         end else begin
            do_ack();
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
